// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes and memory-side signals of mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              resp0_valid;
    logic [DATA_W-1:0] resp0_rdata;
    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp1_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_write;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_data_read;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  mem_data_read,
        output req0_ready, resp0_valid, resp0_rdata,
        output req1_ready, resp1_valid, resp1_rdata,
        output resp_err, mem_address, mem_data_write, mem_write_enable, mem_read_enable
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output mem_data_read,
        input  req0_ready, resp0_valid, resp0_rdata,
        input  req1_ready, resp1_valid, resp1_rdata,
        input  resp_err, mem_address, mem_data_write, mem_write_enable, mem_read_enable
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of a single-port memory between two requesters.
// Optional out-of-range check enabled by defining MEMPORT_ARB_BOUNDS_CHECK_EN.
module mem_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
`ifdef MEMPORT_ARB_BOUNDS_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_next;
    logic              last_grant;
    logic              accept;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;
    logic              req_port;
    logic              req_write;
    logic              req_err;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rdata0, rdata1;

    // arbitration: port 1 wins when alone or when port 0 held the last grant
    always_comb begin
        accept   = (state != ACCESS) && (bus.req0_valid || bus.req1_valid);
        grant    = bus.req1_valid && (!bus.req0_valid || !last_grant);
        sel_addr = grant ? bus.req1_addr : bus.req0_addr;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next state: a single access cycle, then a response cycle that may accept again
    always_comb begin
        state_next = (state == ACCESS) ? RESP : (accept ? ACCESS : IDLE);
    end

    // request register and round-robin history, loaded only on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            req_port   <= 1'b0;
            req_write  <= 1'b0;
            req_err    <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
        end else if (accept) begin
            last_grant <= grant;
            req_port   <= grant;
            req_write  <= grant ? bus.req1_write : bus.req0_write;
            req_err    <= CHECK && (sel_addr >= ADDR_W'(DEPTH));
            req_addr   <= sel_addr;
            req_wdata  <= grant ? bus.req1_wdata : bus.req0_wdata;
        end
    end

    // read data capture at the end of a read access; writes leave rdata untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == ACCESS && !req_write) begin
            if (req_port) rdata1 <= req_err ? '0 : bus.mem_data_read;
            else          rdata0 <= req_err ? '0 : bus.mem_data_read;
        end
    end

    // outputs: enables decoded from registered state only, so they cannot glitch
    always_comb begin
        bus.req0_ready       = accept && !grant;
        bus.req1_ready       = accept && grant;
        bus.mem_write_enable = (state == ACCESS) && req_write && !req_err;
        bus.mem_read_enable  = (state == ACCESS) && !req_write && !req_err;
        bus.resp0_valid      = (state == RESP) && !req_port;
        bus.resp1_valid      = (state == RESP) && req_port;
        bus.resp_err         = (state == RESP) && req_err;
        bus.mem_address      = req_addr;
        bus.mem_data_write   = req_wdata;
        bus.resp0_rdata      = rdata0;
        bus.resp1_rdata      = rdata1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a cycle-level transaction model and literal spot checks
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 256;
    localparam int N = 2048;
`ifdef MEMPORT_ARB_BOUNDS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];
    assign bus.mem_data_read = env_mem[bus.mem_address[7:0]];
    always @(posedge clk) if (bus.mem_write_enable) env_mem[bus.mem_address[7:0]] <= bus.mem_data_write;

    int vectors = 0;
    int errors = 0;
    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // model: an accepted request at cycle c accesses memory in c+1 and responds in c+2
    bit          a_v [N], a_w [N], a_oob [N], a_port [N];
    logic [31:0] a_addr [N], a_wd [N];
    bit          r_v [N], r_port [N], r_err [N], r_upd [N];
    logic [31:0] r_val [N];
    int          mc = 0;
    bit          last = 1'b1;
    logic [31:0] m_rd0 = 0, m_rd1 = 0, hold_addr = 0, hold_wd = 0;

    always @(negedge clk) begin : model
        int idx, nx, g;
        bit ewe, ere;
        logic [31:0] ga;
        idx = mc % N;
        nx = (mc + 1) % N;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                a_v[(mc + k) % N] = 0;
                r_v[(mc + k) % N] = 0;
            end
            last = 1'b1; m_rd0 = 0; m_rd1 = 0; hold_addr = 0; hold_wd = 0;
            chk("rst we", bus.mem_write_enable, 0);
            chk("rst re", bus.mem_read_enable, 0);
            chk("rst rv0", bus.resp0_valid, 0);
            chk("rst rv1", bus.resp1_valid, 0);
            chk("rst err", bus.resp_err, 0);
            chk("rst addr", bus.mem_address, 0);
            chk("rst rd0", bus.resp0_rdata, 0);
            chk("rst rd1", bus.resp1_rdata, 0);
        end else begin
            if (r_v[idx] && r_upd[idx]) begin
                if (r_port[idx]) m_rd1 = r_val[idx];
                else m_rd0 = r_val[idx];
            end
            if (a_v[idx]) begin
                hold_addr = a_addr[idx];
                hold_wd = a_wd[idx];
            end
            ewe = a_v[idx] && a_w[idx] && !a_oob[idx];
            ere = a_v[idx] && !a_w[idx] && !a_oob[idx];
            g = -1;
            if (!a_v[idx]) begin
                if (bus.req0_valid && bus.req1_valid) g = last ? 0 : 1;
                else if (bus.req0_valid) g = 0;
                else if (bus.req1_valid) g = 1;
            end
            chk("ready0", bus.req0_ready, g == 0);
            chk("ready1", bus.req1_ready, g == 1);
            chk("we", bus.mem_write_enable, ewe);
            chk("re", bus.mem_read_enable, ere);
            chk("excl", bus.mem_write_enable & bus.mem_read_enable, 0);
            chk("addr", bus.mem_address, hold_addr);
            chk("wdata", bus.mem_data_write, hold_wd);
            chk("rv0", bus.resp0_valid, r_v[idx] && !r_port[idx]);
            chk("rv1", bus.resp1_valid, r_v[idx] && r_port[idx]);
            chk("err", bus.resp_err, r_v[idx] && r_err[idx]);
            chk("rd0", bus.resp0_rdata, m_rd0);
            chk("rd1", bus.resp1_rdata, m_rd1);
            if (ewe) ref_mem[a_addr[idx][7:0]] = a_wd[idx];
            r_v[nx] = a_v[idx];
            if (a_v[idx]) begin
                r_port[nx] = a_port[idx];
                r_err[nx] = a_oob[idx];
                r_upd[nx] = !a_w[idx];
                r_val[nx] = a_oob[idx] ? 32'h0 : ref_mem[a_addr[idx][7:0]];
            end
            a_v[idx] = 0;
            r_v[idx] = 0;
            if (g >= 0) begin
                last = (g == 1);
                ga = g ? bus.req1_addr : bus.req0_addr;
                a_v[nx] = 1;
                a_port[nx] = (g == 1);
                a_w[nx] = g ? bus.req1_write : bus.req0_write;
                a_addr[nx] = ga;
                a_wd[nx] = g ? bus.req1_wdata : bus.req0_wdata;
                a_oob[nx] = CHK && (ga >= DEPTH);
            end
        end
        mc++;
    end

    task automatic drive(input bit p, input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
        end else begin
            bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
        end
    endtask

    // holds a request until accepted; returns in the following (access) cycle
    task automatic access(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d, output int t);
        drive(p, 1'b1, w, a, d);
        t = -1;
        for (int i = 0; i < 16 && t < 0; i++) begin
            @(negedge clk);
            if (p ? bus.req1_ready : bus.req0_ready) t = tcyc;
        end
        if (t < 0) chk("accept timeout", 0, 1);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, a, 32'h0);
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : stim
        int t, t0, t1, n;
        int gs [4];
        int ts [4];
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset addr", bus.mem_address, 0);
        chk("reset we", bus.mem_write_enable, 0);
        chk("reset rv0", bus.resp0_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(0, 1, 5, 32'hDEADBEEF, t);
        @(negedge clk);
        chk("t1 we", bus.mem_write_enable, 1);
        chk("t1 re", bus.mem_read_enable, 0);
        chk("t1 addr", bus.mem_address, 5);
        chk("t1 wdata", bus.mem_data_write, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1 rv0", bus.resp0_valid, 1);
        chk("t1 we off", bus.mem_write_enable, 0);

        @(posedge clk); #1;
        access(0, 0, 5, 0, t);
        @(negedge clk);
        chk("t2 re", bus.mem_read_enable, 1);
        chk("t2 we", bus.mem_write_enable, 0);
        @(negedge clk);
        chk("t2 rv0", bus.resp0_valid, 1);
        chk("t2 rd0", bus.resp0_rdata, 32'hDEADBEEF);
        chk("t2 rv1", bus.resp1_valid, 0);

        @(posedge clk); #1;
        access(1, 1, 1, 32'h1111_1111, t);
        access(0, 1, 2, 32'h2222_2222, t);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 1, 0, 1, 0);
        drive(1, 1, 0, 2, 0);
        n = 0;
        for (int k = 0; k < 4; k++) begin gs[k] = -1; ts[k] = -1; end
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin gs[n] = 0; ts[n] = tcyc; n++; end
            else if (bus.req1_ready) begin gs[n] = 1; ts[n] = tcyc; n++; end
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("t3 count", n, 4);
        for (int k = 0; k < 4; k++) begin
            chk("t3 grant", gs[k], k % 2);
            chk("t3 spacing", ts[k] - ts[0], 2 * k);
        end
        repeat (3) @(negedge clk);
        chk("t3 rd1", bus.resp1_rdata, 32'h2222_2222);
        chk("t3 rd0", bus.resp0_rdata, 32'h1111_1111);

        @(posedge clk); #1;
        access(0, 0, 1, 0, t0);
        @(posedge clk); #1;
        access(1, 1, 9, 32'hCAFEF00D, t1);
        chk("t4 accept in resp", t1, t0 + 2);
        @(negedge clk);
        chk("t4 rv0 single", bus.resp0_valid, 0);
        chk("t4 we", bus.mem_write_enable, 1);

        repeat (2) @(posedge clk);
        #1;
        access(0, 1, 7, 32'h0000_0077, t);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5 we drop", bus.mem_write_enable, 0);
        chk("t5 re drop", bus.mem_read_enable, 0);
        @(negedge clk);
        chk("t5 no rv0", bus.resp0_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 1, 0, 7, 0);
        drive(1, 1, 0, 3, 0);
        @(negedge clk);
        chk("t5 ready0", bus.req0_ready, 1);
        chk("t5 ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t5 rv0", bus.resp0_valid, 1);
        chk("t5 rd0", bus.resp0_rdata, 32'hA500_0007);

        @(posedge clk); #1;
        access(0, 0, 300, 0, t);
        @(negedge clk);
        chk("t6 addr", bus.mem_address, 300);
`ifdef MEMPORT_ARB_BOUNDS_CHECK_EN
        chk("t6 re", bus.mem_read_enable, 0);
        @(negedge clk);
        chk("t6 rv0", bus.resp0_valid, 1);
        chk("t6 err", bus.resp_err, 1);
        chk("t6 rd0", bus.resp0_rdata, 0);
`else
        chk("t6 re", bus.mem_read_enable, 1);
        @(negedge clk);
        chk("t6 rv0", bus.resp0_valid, 1);
        chk("t6 err", bus.resp_err, 0);
        chk("t6 rd0", bus.resp0_rdata, 32'hA500_002C);
`endif
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-port data memory (256 x 32, combinational read, level-sensitive write/read enables) and shares it between two requesters.
  - Port 0: load/store stage.
  - Port 1: instruction-fetch / loader port.
- Round-robin arbitration, latched request, exactly one memory-enable cycle per access, registered read data and completion pulse back to the winner.
- Guarantees write_enable and read_enable are never high together and never glitch outside the access cycle.

Parameters:
- DATA_W, 32, data width of memory and requester data buses.
- ADDR_W, 32, address width; word addresses, passed straight to memory.
- DEPTH, 256, number of memory words; used only by the optional bounds check.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- req0_valid  in  1  port 0 request pending; held until accepted.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  word address.
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  request accepted this cycle (combinational).
- resp0_valid  out  1  one-cycle completion pulse.
- resp0_rdata  out  DATA_W  read data, valid with resp0_valid.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, resp1_valid, resp1_rdata: same meanings for port 1.
- resp_err  out  1  bounds error flag with any resp pulse (optional feature; constant 0 otherwise).
- mem_address  out  ADDR_W  to memory address.
- mem_data_write  out  DATA_W  to memory data_write.
- mem_write_enable  out  1  to memory write enable.
- mem_read_enable  out  1  to memory read enable.
- mem_data_read  in  DATA_W  from memory data_read.

Behaviour:
- Reset values (asynchronous, rst_n = 0):
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - All resp*_valid, resp_err, mem_*_enable = 0.
  - resp*_rdata, mem_address, mem_data_write = 0.
- States: IDLE, ACCESS, RESP.
- Acceptance (state IDLE or RESP):
  - If any reqN_valid, grant one port and pulse its reqN_ready combinationally.
  - On the clock edge: latch addr/wdata/write/port into the request register and go to ACCESS.
  - With no request: RESP goes to IDLE; IDLE stays in IDLE.
- Arbitration:
  - One valid: grant it.
  - Both valid: grant the port that is not last_grant.
  - last_grant updates on every acceptance.
  - Only one ready is ever high.
- ACCESS, exactly one cycle:
  - Drive mem_address and mem_data_write from the latched request.
  - Write: mem_write_enable = 1. Read: mem_read_enable = 1. Never both.
  - On the edge: capture mem_data_read into the winner's resp_rdata (reads only; rdata for writes holds its previous value), then go to RESP.
- RESP:
  - Winner's resp_valid = 1 for this cycle only; all enables 0.
  - A new request can be accepted in the same cycle.
- Timing: accept at cycle T, memory enable in T+1, resp_valid in T+2. Back-to-back throughput is one access per 2 cycles.
- Outside ACCESS: both enables are 0 and mem_address/mem_data_write hold their last values.
- Requester changing fields while valid and not ready: no effect; only values present at acceptance are used.
- Reset mid-operation: the in-flight access is dropped, no resp pulse is issued, enables drop immediately (asynchronously).
- Addresses are not truncated; the memory sees the full ADDR_W value.

Optional Feature:
- Macro: MEMPORT_ARB_BOUNDS_CHECK_EN.
- Defined:
  - At acceptance, a request with addr >= DEPTH is flagged.
  - Its ACCESS cycle asserts neither enable.
  - The resp pulse carries resp_err = 1; for reads, resp_rdata = 0.
  - Latency is unchanged.
- Undefined:
  - resp_err is tied to 0.
  - All addresses go to memory unchanged.

Test Plan:
- Reset, then port 0 write addr 5 data 0xDEADBEEF: ready0 at T, mem_write_enable only at T+1 with address 5, resp0_valid at T+2, no read enable at any time.
- Port 0 read addr 5 after that write: mem_read_enable at T+1, resp0_valid at T+2 with resp0_rdata = 0xDEADBEEF, resp1_valid stays 0.
- Both ports hold valid reads (addr 1, addr 2) for 4 accesses: grants alternate 0,1,0,1; accepts at cycles 0,2,4,6; port 1 sees its address-2 data.
- Port 1 write issued in RESP of a port 0 read: accepted that cycle, enables never overlap, port 0 resp pulse lasts exactly 1 cycle.
- rst_n pulled low during ACCESS: enables 0 immediately, no resp pulse; after release the next request is serviced with port 0 winning a tie.
- With MEMPORT_ARB_BOUNDS_CHECK_EN, read addr 300 (DEPTH 256): no memory enable, resp_valid at T+2 with resp_err = 1 and rdata 0; without the macro, mem_read_enable rises with address 300.
